mtm_alu_serializer: RTL
=======================

Name: mtm_alu_serializer

Overview:
Transmit side of the mtm_Alu serial protocol. It accepts a result word and flags, or an error code, from the ALU core on a one-cycle request. It then shifts out the matching response frame sequence on a single serial line, `sout`, MSB first. It is the last stage of mtm_Alu (deserializer -> core -> serializer) and must emit frames the test-bench receiver decodes with the same framing rules as the input side.

Parameters:
IFG_BITS, 1, number of idle '1' bits inserted between consecutive frames; used only when `MTM_SER_IFG_EN` is defined.

Ports:
- clk  input  1  clock, posedge active
- rst  input  1  reset, synchronous, active-high
- rdy_to_send  input  1  one-cycle request to send a data response
- rdy_to_send_err  input  1  one-cycle request to send an error response
- C_in  input  32  ALU result
- flags_in  input  4  {Carry, Overflow, Zero, Negative}
- err_flg_in  input  6  error flags, e.g. 100100 DATA, 010010 CRC, 001001 OP
- sout  output  1  serial output, idles high
- busy  output  1  high while a response is being shifted out

Behaviour:
- Reset: `sout`=1, `busy`=0, FSM=IDLE, all counters and shift registers 0. Reset asserted mid-frame aborts the frame: `sout`=1 and `busy`=0 on the cycle after `rst` is sampled high.
- Frame format, 11 bits, one bit per clk: start 0, type bit, 8 payload bits MSB first, stop 1. Type 0 = data frame, type 1 = control frame.
- Data response (`rdy_to_send`): 5 frames.
  - Frames 1-4: data frames carrying C_in[31:24], [23:16], [15:8], [7:0].
  - Frame 5: control frame with payload {1'b0, flags_in[3:0], crc3[2:0]}.
  - crc3: polynomial x^3+x+1, init 000, over the 37-bit vector {C_in, 1'b0, flags_in}, MSB first.
  - Total 55 bits.
- Error response (`rdy_to_send_err`): 1 control frame with payload {1'b1, err_flg_in[5:0], par}.
  - par = XOR of {1'b1, err_flg_in}, i.e. even parity over the payload.
- Input capture: `C_in`, `flags_in`, `err_flg_in` are latched on the request cycle. Later input changes do not affect the frame in flight.
- Latency: request sampled high at edge N -> start bit on `sout` after edge N+1. `busy` rises with the start bit. `busy` falls after the final stop bit's cycle, so `sout` is back in idle.
- Requests while `busy`=1 are ignored, no queueing.
- Both requests in the same cycle: error response takes priority; data request dropped.
- Frames are back-to-back with no gap when `MTM_SER_IFG_EN` is undefined.
- FSM states:
  - IDLE: `sout`=1; go to START on a request.
  - START: `sout`=0, 1 cycle.
  - TYPE: 1 cycle.
  - PAYLOAD: 8 cycles, counted by bit_cnt 0..7.
  - STOP: `sout`=1, 1 cycle.
  - GAP: only with macro.
  - After STOP: go to START if frames remain, else IDLE.
- Counters: frame_cnt 0..4 for the data response, 0 for the error response. bit_cnt wraps to 0 at every frame start.
- CRC3 is computed combinationally from the latched values when latching, or serially during frames 1-4. Either way it is valid before frame 5 starts.
- `sout` is driven directly from a flop, with no combinational path from the inputs.

Optional Feature:
- `MTM_SER_IFG_EN`: when defined, a GAP state drives `sout`=1 for IFG_BITS cycles after each STOP that is followed by another frame of the same response.
  - Data response length = 55 + 4*IFG_BITS cycles.
  - Error response length is unchanged at 11 cycles.
  - `busy` stays high through the gaps.
- When undefined, the GAP state and IFG_BITS logic are absent; frames are contiguous.

Test Plan:
- Reset then idle 20 cycles -> `sout`=1, `busy`=0 throughout.
- `rdy_to_send` with C_in=0x12345678, flags=0000 -> data payloads 0x12, 0x34, 0x56, 0x78, then control payload matching the CRC3 model; `busy` high exactly 55 cycles; start bit one cycle after the request.
- C_in=0x00000000, flags=0000 -> control payload 0x00 (crc3=000); frames 1-4 have payload 0x00 and type 0.
- `rdy_to_send_err` with err 100100, 010010, 001001 -> single frame, type 1, payload 0xC9, 0xA5, 0x93 respectively; 11 cycles.
- Both requests in the same cycle (err=010010), plus a second request mid-frame -> only the 0xA5 error frame is sent; the mid-frame request is ignored; inputs changed after the request have no effect.
- `rst` asserted at bit 30 of a data response -> `sout`=1 and `busy`=0 next cycle; a new request after reset sends a full correct response. With `MTM_SER_IFG_EN`, IFG_BITS=2 -> data response 63 cycles, two idle '1' bits between frames.

Source files
------------

// File: rtl/mtm_alu_serializer.sv
// mtm_Alu response serializer: shifts data/error response frames out on sout, MSB first.
// Define MTM_SER_IFG_EN to insert IFG_BITS idle '1' bits between frames of one response.
module mtm_alu_serializer #(
   parameter int unsigned IFG_BITS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy_to_send,
   input  logic        rdy_to_send_err,
   input  logic [31:0] C_in,
   input  logic [3:0]  flags_in,
   input  logic [5:0]  err_flg_in,
   output logic        sout,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_TYPE,
      S_PAYLOAD,
      S_STOP
`ifdef MTM_SER_IFG_EN
      , S_GAP
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q;
   logic [2:0]  frame_cnt_q;
   logic [31:0] c_q;
   logic [3:0]  flags_q;
   logic [5:0]  err_q;
   logic [2:0]  crc_q;
   logic        is_err_q;
   logic [7:0]  cur_byte;
   logic        sout_d;
   logic        accept;
   logic        last_frame;
`ifdef MTM_SER_IFG_EN
   logic [31:0] gap_cnt_q;
   logic        last_gap;
   assign last_gap = (gap_cnt_q == 32'(IFG_BITS - 1));
`endif

   // x^3+x+1, init 000, over {c, 1'b0, f} MSB first
   function automatic logic [2:0] crc3_calc(input logic [31:0] c, input logic [3:0] f);
      logic [36:0] v;
      logic [2:0]  crc;
      logic        fb;
      v   = {c, 1'b0, f};
      crc = '0;
      for (int unsigned i = 0; i < 37; i++) begin
         fb  = v[36 - i] ^ crc[2];
         crc = {crc[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
      end
      return crc;
   endfunction

   // busy still covers the final stop bit while the FSM is already back in IDLE
   assign accept     = (state_q == S_IDLE) && !busy && (rdy_to_send || rdy_to_send_err);
   assign last_frame = is_err_q || (frame_cnt_q == 3'd4);

   always_comb begin
      cur_byte = '0;
      if (is_err_q) begin
         cur_byte = {1'b1, err_q, ^{1'b1, err_q}};
      end else begin
         case (frame_cnt_q)
            3'd0:    cur_byte = c_q[31:24];
            3'd1:    cur_byte = c_q[23:16];
            3'd2:    cur_byte = c_q[15:8];
            3'd3:    cur_byte = c_q[7:0];
            default: cur_byte = {1'b0, flags_q, crc_q};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // sout_d is the bit for the current state; the output flop presents it one cycle later
   always_comb begin
      state_d = state_q;
      sout_d  = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_START;
         end
         S_START: begin
            sout_d  = 1'b0;
            state_d = S_TYPE;
         end
         S_TYPE: begin
            sout_d  = last_frame;
            state_d = S_PAYLOAD;
         end
         S_PAYLOAD: begin
            sout_d = cur_byte[3'd7 - bit_cnt_q];
            if (bit_cnt_q == 3'd7) state_d = S_STOP;
         end
         S_STOP: begin
            if (last_frame) state_d = S_IDLE;
`ifdef MTM_SER_IFG_EN
            else            state_d = (IFG_BITS != 0) ? S_GAP : S_START;
`else
            else            state_d = S_START;
`endif
         end
`ifdef MTM_SER_IFG_EN
         S_GAP: begin
            if (last_gap) state_d = S_START;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q   <= '0;
         frame_cnt_q <= '0;
         c_q         <= '0;
         flags_q     <= '0;
         err_q       <= '0;
         crc_q       <= '0;
         is_err_q    <= 1'b0;
`ifdef MTM_SER_IFG_EN
         gap_cnt_q   <= '0;
`endif
      end else begin
         if (accept) begin
            c_q         <= C_in;
            flags_q     <= flags_in;
            err_q       <= err_flg_in;
            crc_q       <= crc3_calc(C_in, flags_in);
            is_err_q    <= rdy_to_send_err;
            frame_cnt_q <= '0;
         end
         case (state_q)
            S_START:   bit_cnt_q <= '0;
            S_PAYLOAD: bit_cnt_q <= bit_cnt_q + 3'd1;
            S_STOP: begin
               if (!last_frame) frame_cnt_q <= frame_cnt_q + 3'd1;
`ifdef MTM_SER_IFG_EN
               gap_cnt_q <= '0;
`endif
            end
`ifdef MTM_SER_IFG_EN
            S_GAP:     gap_cnt_q <= gap_cnt_q + 32'd1;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sout <= 1'b1;
         busy <= 1'b0;
      end else begin
         sout <= sout_d;
         busy <= (state_q != S_IDLE);
      end
   end

endmodule
